// File: rtl/fix2flt_pkg.sv
// Shared types and helpers for the fixed-to-float converter.
// Holds the FSM state encoding, rounding-mode codes and width helpers.
package fix2flt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        RND  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic RND_TRUNC = 1'b0;
    localparam logic RND_RNE   = 1'b1;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Signed exponent arithmetic width: room for shift count, field and sign.
    function automatic int exp_calc_w(input int w, input int exp_w);
        return $clog2(w) + exp_w + 2;
    endfunction

endpackage

// File: rtl/fix2flt_round.sv
// Rounding/packing stage: normalised magnitude -> packed float plus status flags.
// Latency: combinational. Backpressure: none, the FSM registers the outputs.
module fix2flt_round
    import fix2flt_pkg::*;
#(
    parameter int INT_W   = 8,
    parameter int FRAC_W  = 8,
    parameter int EXP_W   = 5,
    parameter int MAN_W   = 10,
    parameter int SAT_INF = 1,
    localparam int W      = INT_W + FRAC_W,
    localparam int LZ_W   = $clog2(W),
    localparam int FLT_W  = 1 + EXP_W + MAN_W
) (
    input  logic             sign,
    input  logic [W-2:0]     mag_frac,
    input  logic [LZ_W-1:0]  lz,
    input  logic             rnd_mode,
    output logic [FLT_W-1:0] flt,
    output logic             ovf,
    output logic             uflow,
    output logic             inexact
);

    localparam int EW    = exp_calc_w(W, EXP_W);
    localparam int FW    = W + MAN_W;
    localparam int E_OFF = W - 1 - FRAC_W + bias(EXP_W);
    localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] E_ONE = EW'(1);

    // Zero padding on the right covers MAN_W wider than the fraction bits.
    logic [FW-1:0]        frac;
    logic [MAN_W-1:0]     mant;
    logic                 guard;
    logic                 sticky;
    logic                 round_up;
    logic [MAN_W:0]       mant_sum;
    logic signed [EW-1:0] e_raw;
    logic signed [EW-1:0] e_fin;

    always_comb begin
        frac     = {mag_frac, {(MAN_W + 1){1'b0}}};
        mant     = frac[FW-1 -: MAN_W];
        guard    = frac[FW-1-MAN_W];
        sticky   = |frac[FW-2-MAN_W:0];
        round_up = (rnd_mode == RND_RNE) && guard && (sticky || mant[0]);
        mant_sum = {1'b0, mant} + {{MAN_W{1'b0}}, round_up};
        e_raw    = EW'(E_OFF) - EW'(lz);
        e_fin    = e_raw + EW'(mant_sum[MAN_W]);

        ovf     = 1'b0;
        uflow   = 1'b0;
        inexact = guard | sticky;
        flt     = {sign, e_fin[EXP_W-1:0], mant_sum[MAN_W-1:0]};
        if (e_fin >= E_MAX) begin
            ovf = 1'b1;
            if (SAT_INF != 0)
                flt = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            else
                flt = {sign, {(EXP_W - 1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        end else if (e_fin < E_ONE) begin
            uflow = 1'b1;
            flt   = {sign, {(FLT_W - 1){1'b0}}};
        end
    end

endmodule

// File: rtl/fix2flt_seq.sv
// Start/done coprocessor converting signed fixed point to binary float.
// Latency: lz+2 edges after start (1 for zero). Backpressure: start ignored while busy.
module fix2flt_seq
    import fix2flt_pkg::*;
#(
    parameter int INT_W   = 8,
    parameter int FRAC_W  = 8,
    parameter int EXP_W   = 5,
    parameter int MAN_W   = 10,
    parameter int SAT_INF = 1,
    localparam int W      = INT_W + FRAC_W,
    localparam int FLT_W  = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             rnd_mode,
    input  logic [W-1:0]     fix_in,
    output logic             busy,
    output logic             done,
    output logic [FLT_W-1:0] flt_out,
    output logic             ovf,
    output logic             uflow,
    output logic             inexact
);

    localparam int LZ_W = $clog2(W);

    state_e            state_q, state_d;
    logic              sign_q, sign_d;
    logic [W-1:0]      mag_q, mag_d;
    logic [LZ_W-1:0]   lz_q, lz_d;
    logic              rnd_q, rnd_d;
    logic [FLT_W-1:0]  flt_q, flt_d;
    logic              ovf_q, ovf_d;
    logic              uflow_q, uflow_d;
    logic              inexact_q, inexact_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic [FLT_W-1:0]  r_flt;
    logic              r_ovf, r_uflow, r_inexact;

    fix2flt_round #(
        .INT_W   (INT_W),
        .FRAC_W  (FRAC_W),
        .EXP_W   (EXP_W),
        .MAN_W   (MAN_W),
        .SAT_INF (SAT_INF)
    ) u_round (
        .sign     (sign_q),
        .mag_frac (mag_q[W-2:0]),
        .lz       (lz_q),
        .rnd_mode (rnd_q),
        .flt      (r_flt),
        .ovf      (r_ovf),
        .uflow    (r_uflow),
        .inexact  (r_inexact)
    );

    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        mag_d     = mag_q;
        lz_d      = lz_q;
        rnd_d     = rnd_q;
        flt_d     = flt_q;
        ovf_d     = ovf_q;
        uflow_d   = uflow_q;
        inexact_d = inexact_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // Max-negative negates to itself, which is the right unsigned magnitude.
                    sign_d  = fix_in[W-1];
                    mag_d   = fix_in[W-1] ? (~fix_in + W'(1)) : fix_in;
                    rnd_d   = rnd_mode;
                    lz_d    = '0;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (mag_q == '0) begin
                    flt_d     = '0;
                    ovf_d     = 1'b0;
                    uflow_d   = 1'b0;
                    inexact_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end else if (mag_q[W-1]) begin
                    state_d = RND;
                end else begin
                    mag_d = mag_q << 1;
                    lz_d  = lz_q + LZ_W'(1);
                end
            end
            RND: begin
                flt_d     = r_flt;
                ovf_d     = r_ovf;
                uflow_d   = r_uflow;
                inexact_d = r_inexact;
                done_d    = 1'b1;
                state_d   = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            sign_q    <= 1'b0;
            mag_q     <= '0;
            lz_q      <= '0;
            rnd_q     <= 1'b0;
            flt_q     <= '0;
            ovf_q     <= 1'b0;
            uflow_q   <= 1'b0;
            inexact_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sign_q    <= sign_d;
            mag_q     <= mag_d;
            lz_q      <= lz_d;
            rnd_q     <= rnd_d;
            flt_q     <= flt_d;
            ovf_q     <= ovf_d;
            uflow_q   <= uflow_d;
            inexact_q <= inexact_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign flt_out = flt_q;
    assign ovf     = ovf_q;
    assign uflow   = uflow_q;
    assign inexact = inexact_q;

endmodule

// File: tb/tb_fix2flt_seq.sv
// Directed and randomised checks of fix2flt_seq at default and wide/narrow parameter sets.
module tb_fix2flt_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, rnd_mode;
    logic [15:0] fix_in;
    logic        busy, done, ovf, uflow, inexact;
    logic [15:0] flt_out;

    logic        w_start, w_rnd;
    logic [23:0] w_fix;
    logic        w1_busy, w1_done, w1_ovf, w1_uflow, w1_inx;
    logic        w0_busy, w0_done, w0_ovf, w0_uflow, w0_inx;
    logic        wu_busy, wu_done, wu_ovf, wu_uflow, wu_inx;
    logic [15:0] w1_flt, w0_flt, wu_flt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fix2flt_seq dut (
        .clk(clk), .reset(reset), .start(start), .rnd_mode(rnd_mode), .fix_in(fix_in),
        .busy(busy), .done(done), .flt_out(flt_out), .ovf(ovf), .uflow(uflow), .inexact(inexact)
    );

    fix2flt_seq #(.INT_W(24), .FRAC_W(0), .SAT_INF(1)) u_w1 (
        .clk(clk), .reset(reset), .start(w_start), .rnd_mode(w_rnd), .fix_in(w_fix),
        .busy(w1_busy), .done(w1_done), .flt_out(w1_flt), .ovf(w1_ovf), .uflow(w1_uflow), .inexact(w1_inx)
    );

    fix2flt_seq #(.INT_W(24), .FRAC_W(0), .SAT_INF(0)) u_w0 (
        .clk(clk), .reset(reset), .start(w_start), .rnd_mode(w_rnd), .fix_in(w_fix),
        .busy(w0_busy), .done(w0_done), .flt_out(w0_flt), .ovf(w0_ovf), .uflow(w0_uflow), .inexact(w0_inx)
    );

    fix2flt_seq #(.INT_W(4), .FRAC_W(20), .SAT_INF(1)) u_wu (
        .clk(clk), .reset(reset), .start(w_start), .rnd_mode(w_rnd), .fix_in(w_fix),
        .busy(wu_busy), .done(wu_done), .flt_out(wu_flt), .ovf(wu_ovf), .uflow(wu_uflow), .inexact(wu_inx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference for the default 8.8 -> 1.5.10 format, built from the leading-one position.
    function automatic void model(input logic [15:0] v, input logic m,
                                  output logic [15:0] f, output logic inx, output int lat);
        logic s;
        int mag, p, e, sh, mant, rem, half;
        s = v[15];
        mag = s ? (65536 - int'(v)) : int'(v);
        f = 16'h0000;
        inx = 1'b0;
        lat = 1;
        if (mag == 0) return;
        p = 0;
        for (int i = 0; i < 17; i++) if (((mag >> i) & 1) != 0) p = i;
        e = p - 8 + 15;
        if (p >= 10) begin
            sh = p - 10;
            mant = (mag >> sh) & 1023;
            rem = mag & ((1 << sh) - 1);
            half = (sh > 0) ? (1 << (sh - 1)) : 0;
            inx = (rem != 0);
            if (m && sh > 0 && (rem > half || (rem == half && (mant & 1) != 0))) mant++;
        end else begin
            mant = (mag << (10 - p)) & 1023;
        end
        if (mant == 1024) begin
            mant = 0;
            e++;
        end
        f = {s, 5'(e), 10'(mant)};
        lat = 15 - p + 2;
    endfunction

    task automatic run(input logic [15:0] v, input logic m, input logic [15:0] ef,
                       input logic einx, input int elat, input string tag);
        int lat;
        start = 1'b1;
        fix_in = v;
        rnd_mode = m;
        @(posedge clk); #1;
        start = 1'b0;
        fix_in = ~v;
        rnd_mode = ~m;
        chk({tag, ".busy_start"}, 32'(busy), 32'd1);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            chk({tag, ".busy"}, 32'(busy), 32'd1);
        end while (!done && lat < 40);
        chk({tag, ".lat"}, 32'(lat), 32'(elat));
        chk({tag, ".flt"}, 32'(flt_out), 32'(ef));
        chk({tag, ".inexact"}, 32'(inexact), 32'(einx));
        chk({tag, ".ovf"}, 32'(ovf), 32'd0);
        chk({tag, ".uflow"}, 32'(uflow), 32'd0);
        @(posedge clk); #1;
        chk({tag, ".done_drop"}, 32'(done), 32'd0);
        chk({tag, ".busy_idle"}, 32'(busy), 32'd0);
        chk({tag, ".hold"}, 32'(flt_out), 32'(ef));
    endtask

    task automatic run_w(input logic [23:0] v, input logic [15:0] e1, input logic [15:0] e0,
                         input logic eovf, input logic einx, input logic [15:0] eu,
                         input logic euf, input logic euinx, input int elat, input string tag);
        int lat;
        w_start = 1'b1;
        w_fix = v;
        w_rnd = 1'b0;
        @(posedge clk); #1;
        w_start = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!w1_done && lat < 60);
        chk({tag, ".lat"}, 32'(lat), 32'(elat));
        chk({tag, ".sat_done"}, 32'(w0_done), 32'd1);
        chk({tag, ".u_done"}, 32'(wu_done), 32'd1);
        chk({tag, ".inf_flt"}, 32'(w1_flt), 32'(e1));
        chk({tag, ".sat_flt"}, 32'(w0_flt), 32'(e0));
        chk({tag, ".inf_ovf"}, 32'(w1_ovf), 32'(eovf));
        chk({tag, ".sat_ovf"}, 32'(w0_ovf), 32'(eovf));
        chk({tag, ".inf_inx"}, 32'(w1_inx), 32'(einx));
        chk({tag, ".inf_uflow"}, 32'(w1_uflow), 32'd0);
        chk({tag, ".u_flt"}, 32'(wu_flt), 32'(eu));
        chk({tag, ".u_uflow"}, 32'(wu_uflow), 32'(euf));
        chk({tag, ".u_ovf"}, 32'(wu_ovf), 32'd0);
        chk({tag, ".u_inx"}, 32'(wu_inx), 32'(euinx));
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rv, ef;
        logic        rm, ei;
        int          el, ndone;

        reset = 1'b0;
        start = 1'b0;
        rnd_mode = 1'b0;
        fix_in = 16'h0000;
        w_start = 1'b0;
        w_rnd = 1'b0;
        w_fix = 24'h0;
        #12;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.flt", 32'(flt_out), 32'd0);
        chk("rst.flags", 32'({ovf, uflow, inexact}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        run(16'h0001, 1'b0, 16'h1C00, 1'b0, 17, "one");
        run(16'hFFFD, 1'b0, 16'hA200, 1'b0, 16, "neg3");
        run(16'h8000, 1'b0, 16'hD800, 1'b0, 2, "maxneg");
        run(16'h1FFF, 1'b0, 16'h4FFF, 1'b1, 5, "trunc1fff");
        run(16'h0000, 1'b1, 16'h0000, 1'b0, 1, "zero");
        run(16'h1FFF, 1'b1, 16'h5000, 1'b1, 5, "rne1fff");
        run(16'h7FFF, 1'b1, 16'h5800, 1'b1, 3, "rne7fff");
        run(16'h0003, 1'b1, 16'h2200, 1'b0, 16, "rne3");

        // Two-cycle start on a zero operand must yield one conversion only.
        ndone = 0;
        start = 1'b1;
        fix_in = 16'h0000;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (i == 1) start = 1'b0;
            if (done) ndone++;
        end
        chk("start2.ndone", 32'(ndone), 32'd1);

        run(16'hFFFD, 1'b0, 16'hA200, 1'b0, 16, "pre_rst");
        start = 1'b1;
        fix_in = 16'h0001;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.done", 32'(done), 32'd0);
        chk("midrst.flt", 32'(flt_out), 32'd0);
        ndone = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("midrst.nodone", 32'(ndone), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        run(16'h0030, 1'b0, 16'h3200, 1'b0, 12, "post_rst");

        for (int i = 0; i < 120; i++) begin
            rv = 16'($urandom);
            if (i % 7 == 0) rv = rv >> (i % 16);
            rm = 1'(i & 1);
            model(rv, rm, ef, ei, el);
            run(rv, rm, ef, ei, el, $sformatf("rand%0d_%h_%0d", i, rv, rm));
        end

        run_w(24'h7FFFFF, 16'h7C00, 16'h7BFF, 1'b1, 1'b1, 16'h47FF, 1'b0, 1'b1, 3, "w_max");
        run_w(24'hFFFFFF, 16'hBC00, 16'hBC00, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b0, 25, "w_m1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
